// File: rtl/scroll_ctrl.sv
// Scroll-step sequencer for the MAX7219 8x8 column shifter: tick pacing, column fetch, shift pulse, refresh handshake.
// Optional build macro SCROLL_WRAP_EN: an empty fetch recirculates the shifter's outgoing column instead of blanking.
module scroll_ctrl #(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir_in,
  input  logic             col_valid,
  input  logic [7:0]       col_data,
  output logic             col_ready,
  output logic             sh_en,
  output logic             sh_dir,
  output logic [7:0]       sh_d,
  input  logic [7:0]       sh_ex,
  output logic             frame_req,
  input  logic             frame_ack,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_FETCH     = 3'd2,
    S_SHIFT     = 3'd3,
    S_REFRESH   = 3'd4
  } state_t;

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  state_t             state_r;
  logic [TICK_W-1:0]  tick_r;
  logic               dir_r;
  logic [7:0]         d_r;
  logic               take_r;
  logic               stop_pend_r;
  logic [CNT_W-1:0]   step_cnt_r;

  // Sequencer state, tick pacing, latched column and step bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      tick_r      <= '0;
      dir_r       <= 1'b0;
      d_r         <= 8'h00;
      take_r      <= 1'b0;
      stop_pend_r <= 1'b0;
      step_cnt_r  <= '0;
    end else begin
      // A stop seen mid-sequence is remembered; the current step still runs to the end.
      if ((state_r != S_IDLE) && stop) begin
        stop_pend_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (start) begin
            dir_r       <= dir_in;
            tick_r      <= '0;
            step_cnt_r  <= '0;
            stop_pend_r <= 1'b0;
            state_r     <= S_WAIT_TICK;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_WAIT_TICK: begin
          if (tick_r == TICK_LAST) begin
            tick_r  <= '0;
            state_r <= S_FETCH;
          end else begin
            tick_r  <= tick_r + TICK_W'(1);
          end
        end
        S_FETCH: begin
          if (col_valid) begin
            d_r    <= col_data;
            take_r <= 1'b1;
          end else begin
            d_r    <= 8'h00;
            take_r <= 1'b0;
          end
          state_r <= S_SHIFT;
        end
        S_SHIFT: begin
          step_cnt_r <= step_cnt_r + CNT_W'(1);
          state_r    <= S_REFRESH;
        end
        S_REFRESH: begin
          if (frame_ack) begin
            if (stop_pend_r || stop) begin
              stop_pend_r <= 1'b0;
              state_r     <= S_IDLE;
            end else begin
              state_r     <= S_WAIT_TICK;
            end
          end else begin
            state_r <= S_REFRESH;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign col_ready = (state_r == S_FETCH);
  assign sh_en     = (state_r == S_SHIFT);
  assign frame_req = (state_r == S_REFRESH);
  assign busy      = (state_r != S_IDLE);
  assign sh_dir    = dir_r;
  assign step_cnt  = step_cnt_r;

`ifdef SCROLL_WRAP_EN
  // Empty fetch: feed the column leaving the shifter straight back in so the image rotates.
  always_comb begin
    if ((state_r == S_SHIFT) && !take_r) begin
      sh_d = sh_ex;
    end else begin
      sh_d = d_r;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{sh_ex, take_r};
  assign sh_d     = d_r;
`endif

endmodule

// File: tb/tb_scroll_ctrl.sv
// Randomized scoreboard bench for scroll_ctrl: the driver predicts every step from the timing rules, a monitor checks.
module tb_scroll_ctrl;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_n, start, stop, dir_in, col_valid, frame_ack;
  logic [7:0]       col_data, sh_ex;
  logic             col_ready, sh_en, sh_dir, frame_req, busy;
  logic [7:0]       sh_d;
  logic [CNT_W-1:0] step_cnt;

  scroll_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir_in(dir_in),
    .col_valid(col_valid), .col_data(col_data), .col_ready(col_ready),
    .sh_en(sh_en), .sh_dir(sh_dir), .sh_d(sh_d), .sh_ex(sh_ex),
    .frame_req(frame_req), .frame_ack(frame_ack), .busy(busy), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               shift_edge;
    int               ack_edge;
    logic [7:0]       data;
    logic             dir;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   origin = 0;
  int   win_lo = 1;
  int   win_hi = 0;
  bit   mon_en = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: sample just after each edge, pop the scoreboard whenever a shift is presented.
  exp_t mon_e;
  logic exp_sh, exp_rdy, exp_req;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      exp_sh  = (q.size() > 0) && (q[0].shift_edge == edge_n);
      exp_rdy = (q.size() > 0) && (q[0].shift_edge == edge_n + 1);
      exp_req = (edge_n >= win_lo) && (edge_n <= win_hi);
      chk("col_ready", 32'(col_ready), 32'(exp_rdy));
      chk("sh_en", 32'(sh_en), 32'(exp_sh));
      chk("frame_req", 32'(frame_req), 32'(exp_req));
      if (sh_en && (q.size() > 0)) begin
        mon_e = q.pop_front();
        chk("shift_edge", 32'(edge_n), 32'(mon_e.shift_edge));
        chk("sh_d", 32'(sh_d), 32'(mon_e.data));
        chk("sh_dir", 32'(sh_dir), 32'(mon_e.dir));
        chk("step_cnt_in_shift", 32'(step_cnt), 32'(mon_e.cnt));
        win_lo = mon_e.shift_edge + 1;
        win_hi = mon_e.ack_edge - 1;
      end else if ((q.size() > 0) && (q[0].shift_edge < edge_n)) begin
        mon_e = q.pop_front();
      end
    end
  end

  // One scroll step starting from the cycle the DUT entered its tick wait (edge "origin").
  task automatic do_step(input bit last, input int d, input logic dir, input logic [CNT_W-1:0] cnt_before);
    exp_t       e;
    logic       v;
    logic [7:0] dat, ex;
    v   = 1'($urandom);
    dat = 8'($urandom);
    ex  = 8'($urandom);
    e.shift_edge = origin + TICK_DIV + 1;
    e.ack_edge   = origin + TICK_DIV + 3 + d;
`ifdef SCROLL_WRAP_EN
    e.data = v ? dat : ex;
`else
    e.data = v ? dat : 8'h00;
`endif
    e.dir = dir;
    e.cnt = cnt_before;
    q.push_back(e);
    for (int j = 1; j <= TICK_DIV + 3 + d; j++) begin
      @(negedge clk);
      start     = 1'b0;
      stop      = 1'b0;
      frame_ack = 1'b0;
      dir_in    = 1'($urandom);
      col_valid = 1'($urandom);
      col_data  = 8'($urandom);
      if (j <= TICK_DIV) begin
        start     = 1'($urandom);
        frame_ack = 1'($urandom);
        if (last && (j == 1)) stop = 1'b1;
      end
      if (j == TICK_DIV + 1) begin
        chk("busy_in_step", 32'(busy), 32'd1);
        col_valid = v;
        col_data  = dat;
        sh_ex     = ex;
      end
      if (j == TICK_DIV + 3 + d) frame_ack = 1'b1;
    end
    origin = origin + TICK_DIV + 3 + d;
  endtask

  // A full scroll session: start, nsteps steps with stop during the last one, then idle checks.
  task automatic session(input int nsteps, input logic dir, input int long_step);
    int d;
    @(negedge clk);
    start     = 1'b1;
    dir_in    = dir;
    stop      = 1'($urandom);
    frame_ack = 1'b0;
    origin    = edge_n + 1;
    for (int s = 0; s < nsteps; s++) begin
      d = (s == long_step) ? 20 : $urandom_range(0, 3);
      do_step(s == nsteps - 1, d, dir, CNT_W'(s));
    end
    for (int k = 0; k < 2 * TICK_DIV + 6; k++) begin
      @(negedge clk);
      start     = 1'b0;
      stop      = 1'($urandom);
      frame_ack = 1'($urandom);
      dir_in    = 1'($urandom);
      col_valid = 1'($urandom);
      col_data  = 8'($urandom);
    end
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("step_cnt_final", 32'(step_cnt), 32'(nsteps));
    chk("sh_dir_idle", 32'(sh_dir), 32'(dir));
    frame_ack = 1'b0;
    stop      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir_in = 1'b0; col_valid = 1'b0;
    col_data = 8'h00; frame_ack = 1'b0; sh_ex = 8'h3C;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sh_en", 32'(sh_en), 32'd0);
    chk("rst_frame_req", 32'(frame_req), 32'd0);
    chk("rst_col_ready", 32'(col_ready), 32'd0);
    chk("rst_sh_dir", 32'(sh_dir), 32'd0);
    chk("rst_sh_d", 32'(sh_d), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    rst_n = 1'b1;

    // Directed step with a fixed column, then reset while the refresh is pending.
    @(negedge clk);
    start = 1'b1; dir_in = 1'b0; col_valid = 1'b1; col_data = 8'hA5;
    for (int j = 1; j <= TICK_DIV + 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == TICK_DIV + 2) begin
        chk("dir_sh_en", 32'(sh_en), 32'd1);
        chk("dir_sh_d", 32'(sh_d), 32'hA5);
        chk("dir_sh_dir", 32'(sh_dir), 32'd0);
      end
    end
    chk("dir_frame_req", 32'(frame_req), 32'd1);
    chk("dir_step_cnt", 32'(step_cnt), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_frame_req", 32'(frame_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_step_cnt", 32'(step_cnt), 32'd0);
    chk("midrst_sh_en", 32'(sh_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    session(4, 1'b0, -1);
    session(3, 1'b1, 1);
    session(5, 1'b1, 2);
    session(1, 1'b0, 0);
    for (int k = 0; k < 6; k++) begin
      session($urandom_range(1, 6), 1'($urandom), $urandom_range(0, 5));
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
